simon_keyexpansion_rev: RTL and testbench

//  Reverse SIMON 32/64 key schedule for the decryption datapath. Loads the last M

---
 rtl/simon_keyexpansion_rev.sv | 153 +++++++++++++++
 tb/tb_simon_keyexpansion_rev.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/simon_keyexpansion_rev.sv
// ---------------------------------------------------------------------------
// simon_keyexpansion_rev
//
// Reverse SIMON 32/64 key schedule. The block is loaded with the last four
// round keys k[T-4..T-1]. It then emits k[T-1] down to k[0], one key per
// rk_valid/rk_ready beat. Each earlier key is recovered by inverting the
// forward key-expansion recurrence.
//
// Ports
//   clk        in   rising-edge clock
//   n_reset    in   asynchronous active-low reset
//   load       in   start request, sampled only in IDLE
//   last_keys  in   last_keys[j] = k[T-4+j]
//   busy       out  high while a sequence is being produced
//   rk         out  current round key (registered)
//   rk_idx     out  index of rk, counts T-1 down to 0
//   rk_valid   out  rk/rk_idx valid
//   rk_ready   in   consumer accepts rk this cycle
//   abort      in   (only with SIMON_KEYREV_ABORT_EN) cancel the running sequence
//   done       out  one-cycle pulse after k[0] has been accepted
//
// Optional feature macro: SIMON_KEYREV_ABORT_EN
//
// State | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for load; outputs hold their last values
// RUN   | rk_valid high, one key is emitted per accepted beat
// ---------------------------------------------------------------------------
module simon_keyexpansion_rev #(
    parameter int          N = 16,
    parameter int          M = 4,
    parameter int          T = 32,
    parameter logic [61:0] Z = 62'b11111010001001010110000111001101111101000100101011000011100110
) (
    input  logic                  clk,
    input  logic                  n_reset,
    input  logic                  load,
    input  logic [M-1:0][N-1:0]   last_keys,
    output logic                  busy,
    output logic [N-1:0]          rk,
    output logic [5:0]            rk_idx,
    output logic                  rk_valid,
    input  logic                  rk_ready,
`ifdef SIMON_KEYREV_ABORT_EN
    input  logic                  abort,
`endif
    output logic                  done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             r_state;
    logic [N-1:0]       r_w [4];
    logic [5:0]         r_idx;
    logic               r_valid;
    logic               r_busy;
    logic               r_done;

    logic               w_beat;
    logic               w_abort;
    logic [5:0]         w_i;
    logic [5:0]         w_zpos;
    logic               w_zbit;
    logic [N-1:0]       w_t0;
    logic [N-1:0]       w_t1;
    logic [N-1:0]       w_knew;

`ifdef SIMON_KEYREV_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_beat = r_valid & rk_ready;

    // The window holds k[base..base+3] and rk_idx = base+3, so the key being
    // recovered is k[rk_idx-4]. It pairs with z bit (rk_idx-4) mod 62. Z bit 0 is
    // the leftmost literal bit. The value is only used when rk_idx > 3.
    assign w_i    = r_idx - 6'd4;
    assign w_zpos = 6'd61 - (w_i % 6'd62);
    assign w_zbit = Z[w_zpos];

    // Inverse of k[i+4] = ~k[i] ^ t ^ z ^ 3, where
    // t = ROR3(k[i+3]) ^ k[i+1] followed by t ^= ROR1(t).
    assign w_t0   = {r_w[2][2:0], r_w[2][N-1:3]} ^ r_w[0];
    assign w_t1   = w_t0 ^ {w_t0[0], w_t0[N-1:1]};
    assign w_knew = {{(N-2){1'b1}}, 2'b00} ^ r_w[3] ^ w_t1 ^ {{(N-1){1'b0}}, w_zbit};

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state <= IDLE;
            r_w[0]  <= '0;
            r_w[1]  <= '0;
            r_w[2]  <= '0;
            r_w[3]  <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (load) begin
                        r_w[0]  <= last_keys[0];
                        r_w[1]  <= last_keys[1];
                        r_w[2]  <= last_keys[2];
                        r_w[3]  <= last_keys[3];
                        r_idx   <= 6'(T - 1);
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (w_abort) begin
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else if (w_beat) begin
                        if (r_idx == 6'd0) begin
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= IDLE;
                        end else begin
                            r_w[3] <= r_w[2];
                            r_w[2] <= r_w[1];
                            r_w[1] <= r_w[0];
                            // When fewer than four keys remain, the window already
                            // holds everything left to emit, so nothing new is computed.
                            if (r_idx > 6'd3) begin
                                r_w[0] <= w_knew;
                            end
                            r_idx <= r_idx - 6'd1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rk       = r_w[3];
    assign rk_idx   = r_idx;
    assign rk_valid = r_valid;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_simon_keyexpansion_rev.sv
module tb_simon_keyexpansion_rev;

    logic              clk;
    logic              n_reset;
    logic              load;
    logic [3:0][15:0]  last_keys;
    logic              busy;
    logic [15:0]       rk;
    logic [5:0]        rk_idx;
    logic              rk_valid;
    logic              rk_ready;
    logic              abort;
    logic              done;

    int n_chk  = 0;
    int n_pass = 0;

    logic [15:0] mk [32];
    logic [15:0] kref [8];
    logic [61:0] zc = 62'b11111010001001010110000111001101111101000100101011000011100110;
    localparam logic [63:0] KEY0 = 64'h1918_1110_0908_0100;

    simon_keyexpansion_rev dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .load      (load),
        .last_keys (last_keys),
        .busy      (busy),
        .rk        (rk),
        .rk_idx    (rk_idx),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
`ifdef SIMON_KEYREV_ABORT_EN
        .abort     (abort),
`endif
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [15:0] ror(input logic [15:0] x, input int s);
        return (x >> s) | (x << (16 - s));
    endfunction

    // Forward SIMON 32/64 key expansion; the DUT must reproduce it backwards.
    task automatic build_model(input logic [63:0] key);
        logic [15:0] tmp;
        for (int j = 0; j < 4; j++) mk[j] = key[16*j +: 16];
        for (int i = 0; i < 28; i++) begin
            tmp = ror(mk[i+3], 3) ^ mk[i+1];
            tmp = tmp ^ ror(tmp, 1);
            mk[i+4] = ~mk[i] ^ tmp ^ 16'(zc[61 - (i % 62)]) ^ 16'd3;
        end
    endtask

    task automatic start(input logic [63:0] key);
        build_model(key);
        last_keys = {mk[31], mk[30], mk[29], mk[28]};
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_valid", 32'(rk_valid), 32'd0);
        load = 1'b1;
    endtask

    // Consumes one sequence, checking every sampled cycle against the model.
    task automatic run_keys(input int pct, input int load_idx, input int rst_idx,
                            input int abort_idx, input bit hold_load, input bit known);
        int e = 31;
        bit fin = 1'b0;
        for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
            @(negedge clk);
            if (e < 0) begin
                chk("done_pulse", 32'(done), 32'd1);
                chk("busy_end", 32'(busy), 32'd0);
                chk("valid_end", 32'(rk_valid), 32'd0);
                fin = 1'b1;
            end else begin
                chk("valid", 32'(rk_valid), 32'd1);
                chk("busy", 32'(busy), 32'd1);
                chk("done_low", 32'(done), 32'd0);
                chk("rk_idx", 32'(rk_idx), 32'(e));
                chk("rk", 32'(rk), 32'(mk[e]));
                if (known && e <= 7) chk("rk_vector", 32'(rk), 32'(kref[e]));
                if (e == rst_idx) begin
                    n_reset  = 1'b0;
                    load     = 1'b0;
                    rk_ready = 1'b0;
                    #1;
                    chk("rst_valid", 32'(rk_valid), 32'd0);
                    chk("rst_busy", 32'(busy), 32'd0);
                    chk("rst_idx", 32'(rk_idx), 32'd0);
                    #2;
                    n_reset = 1'b1;
                    fin = 1'b1;
                end else if (e == abort_idx) begin
                    abort    = 1'b1;
                    rk_ready = 1'b1;
                    load     = 1'b0;
                    @(negedge clk);
                    abort    = 1'b0;
                    rk_ready = 1'b0;
                    chk("abort_valid", 32'(rk_valid), 32'd0);
                    chk("abort_busy", 32'(busy), 32'd0);
                    chk("abort_idx_held", 32'(rk_idx), 32'(e));
                    for (int k = 0; k < 3; k++) begin
                        chk("abort_no_done", 32'(done), 32'd0);
                        @(negedge clk);
                    end
                    fin = 1'b1;
                end else begin
                    load     = hold_load || (e == load_idx);
                    rk_ready = ($urandom_range(99) < pct);
                    if (rk_ready) e--;
                end
            end
        end
        if (!fin) chk("timeout", 32'd0, 32'd1);
        rk_ready = 1'b0;
        if (!hold_load) load = 1'b0;
    endtask

    initial begin
        kref[7] = 16'he070; kref[6] = 16'h56d4; kref[5] = 16'hb649; kref[4] = 16'h71c3;
        kref[3] = 16'h1918; kref[2] = 16'h1110; kref[1] = 16'h0908; kref[0] = 16'h0100;
        n_reset   = 1'b0;
        load      = 1'b0;
        rk_ready  = 1'b0;
        abort     = 1'b0;
        last_keys = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_valid", 32'(rk_valid), 32'd0);
        chk("reset_idx", 32'(rk_idx), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_rk", 32'(rk), 32'd0);
        n_reset = 1'b1;

        // A ready without valid in IDLE must not start anything.
        rk_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_ready_valid", 32'(rk_valid), 32'd0);
            chk("idle_ready_busy", 32'(busy), 32'd0);
        end
        rk_ready = 1'b0;

        start(KEY0); run_keys(100, -1, -1, -1, 1'b0, 1'b1);
        start(KEY0); run_keys(50,  -1, -1, -1, 1'b0, 1'b1);
        start(KEY0); run_keys(70,  20, -1, -1, 1'b0, 1'b1);
        start(KEY0); run_keys(80,  -1, 15, -1, 1'b0, 1'b1);
        start(KEY0); run_keys(100, -1, -1, -1, 1'b0, 1'b1);

        // Load held through done: the reload is taken in the done cycle.
        start(KEY0); run_keys(100, -1, -1, -1, 1'b1, 1'b1);
        @(posedge clk);
        #1 load = 1'b0;
        run_keys(60, -1, -1, -1, 1'b0, 1'b1);

`ifdef SIMON_KEYREV_ABORT_EN
        start(KEY0); run_keys(100, -1, -1, 10, 1'b0, 1'b1);
        start(KEY0); run_keys(100, -1, -1, -1, 1'b0, 1'b1);
`endif

        for (int r = 0; r < 4; r++) begin
            start({$urandom, $urandom});
            run_keys(30 + 20 * r, -1, -1, -1, 1'b0, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
